fp_booth_multiplier: RTL and testbench

Sequential floating-point multiplier for the custom FPU datapath. It multiplies two IEEE-754 binary32 operands, or two bfloat16 operands selected by `mode`. Significands are multiplied by an iterative radix-4 Booth engine, and the result is reported with a start/done handshake. The block sits behind the FPU operand registers, and its `Product` feeds the FPU result mux.

---
 rtl/fp_booth_multiplier.sv | 175 +++++++++++++++++
 tb/tb_fp_booth_multiplier.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/fp_booth_multiplier.sv
// Sequential binary32/bfloat16 multiplier: radix-4 Booth significand engine,
// truncating normalization, flush-to-zero, start/done handshake.
module fp_booth_multiplier (
  input  logic        Clock,
  input  logic        reset,
  input  logic [31:0] A,
  input  logic [31:0] B,
  input  logic        start,
  input  logic        mode,
  output logic [31:0] Product,
  output logic        done
);

  localparam int unsigned SW = 24;   // significand register width
  localparam int unsigned AW = 50;   // signed accumulator width
  localparam int unsigned CW = 4;    // Booth step counter width

  typedef enum logic [2:0] {IDLE, LOAD, MULT, NORM, DONE} state_t;

  state_t              state;
  logic [31:0]         op_a, op_b;
  logic                op_mode;
  logic                sgn, nan_r, inf_r, zero_r, hb_b;
  logic [7:0]          ea, eb;
  logic [SW-1:0]       siga, mplr;
  logic                prev;
  logic signed [AW-1:0] mcand, acc;
  logic [CW-1:0]       cnt;

  // Operand unpacking from the captured registers
  logic          sa_c, sb_c;
  logic [7:0]    ea_c, eb_c;
  logic [22:0]   fa_c, fb_c;
  logic [SW-1:0] siga_c, sigb_c;
  logic          nan_a_c, nan_b_c, inf_a_c, inf_b_c, zero_a_c, zero_b_c;

  always_comb begin
    sa_c     = op_mode ? op_a[15] : op_a[31];
    sb_c     = op_mode ? op_b[15] : op_b[31];
    ea_c     = op_mode ? op_a[14:7] : op_a[30:23];
    eb_c     = op_mode ? op_b[14:7] : op_b[30:23];
    fa_c     = op_mode ? {op_a[6:0], 16'd0} : op_a[22:0];
    fb_c     = op_mode ? {op_b[6:0], 16'd0} : op_b[22:0];
    zero_a_c = (ea_c == 8'd0);
    zero_b_c = (eb_c == 8'd0);
    nan_a_c  = (ea_c == 8'hFF) && (fa_c != 23'd0);
    nan_b_c  = (eb_c == 8'hFF) && (fb_c != 23'd0);
    inf_a_c  = (ea_c == 8'hFF) && (fa_c == 23'd0);
    inf_b_c  = (eb_c == 8'hFF) && (fb_c == 23'd0);
    siga_c   = op_mode ? {16'd0, !zero_a_c, op_a[6:0]} : {!zero_a_c, op_a[22:0]};
    sigb_c   = op_mode ? {16'd0, !zero_b_c, op_b[6:0]} : {!zero_b_c, op_b[22:0]};
  end

  // Radix-4 Booth partial product for the current multiplier triplet
  logic signed [AW-1:0] pp;

  always_comb begin
    pp = '0;
    unique case ({mplr[1:0], prev})
      3'b001, 3'b010: pp = mcand;
      3'b011:         pp = mcand <<< 1;
      3'b100:         pp = -(mcand <<< 1);
      3'b101, 3'b110: pp = -mcand;
      default:        pp = '0;
    endcase
  end

  // The top Booth digit treats the multiplier MSB as a sign; add it back here
  logic signed [AW-1:0] corr, sum;
  logic [47:0]          full, p48;
  logic                 msb;
  logic [22:0]          frac;
  logic signed [9:0]    exp10;
  logic [31:0]          result;
  logic                 unused_bits;

  always_comb begin
    corr = '0;
    if (hb_b)
      corr = op_mode ? $signed({18'd0, siga, 8'd0}) : $signed({2'd0, siga, 24'd0});
    sum   = acc + corr;
    full  = sum[47:0];
    p48   = op_mode ? {full[15:0], 32'd0} : full;
    msb   = p48[47];
    frac  = msb ? p48[46:24] : p48[45:23];
    exp10 = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127 + $signed({9'd0, msb});
    unused_bits = ^{sum[49:48], p48[22:0]};

    if (op_mode)
      result = {16'd0, sgn, exp10[7:0], frac[22:16]};
    else
      result = {sgn, exp10[7:0], frac};

    if (nan_r)
      result = op_mode ? 32'h0000_7FC0 : 32'h7FC0_0000;
    else if (inf_r || exp10 >= 10'sd255)
      result = op_mode ? {16'd0, sgn, 8'hFF, 7'd0} : {sgn, 8'hFF, 23'd0};
    else if (zero_r || exp10 <= 10'sd0)
      result = op_mode ? {16'd0, sgn, 15'd0} : {sgn, 31'd0};
  end

  // Control FSM and datapath registers
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state   <= IDLE;
      op_a    <= '0;
      op_b    <= '0;
      op_mode <= 1'b0;
      sgn     <= 1'b0;
      nan_r   <= 1'b0;
      inf_r   <= 1'b0;
      zero_r  <= 1'b0;
      hb_b    <= 1'b0;
      ea      <= '0;
      eb      <= '0;
      siga    <= '0;
      mplr    <= '0;
      prev    <= 1'b0;
      mcand   <= '0;
      acc     <= '0;
      cnt     <= '0;
      Product <= '0;
      done    <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (start) begin
            op_a    <= A;
            op_b    <= B;
            op_mode <= mode;
            state   <= LOAD;
          end
        end
        LOAD: begin
          sgn    <= sa_c ^ sb_c;
          ea     <= ea_c;
          eb     <= eb_c;
          nan_r  <= nan_a_c || nan_b_c || (inf_a_c && zero_b_c) || (inf_b_c && zero_a_c);
          inf_r  <= inf_a_c || inf_b_c;
          zero_r <= zero_a_c || zero_b_c;
          siga   <= siga_c;
          hb_b   <= op_mode ? sigb_c[7] : sigb_c[23];
          mcand  <= $signed({26'd0, siga_c});
          mplr   <= sigb_c;
          prev   <= 1'b0;
          acc    <= '0;
          cnt    <= '0;
          state  <= MULT;
        end
        MULT: begin
          acc   <= acc + pp;
          mcand <= mcand <<< 2;
          mplr  <= mplr >> 2;
          prev  <= mplr[1];
          cnt   <= cnt + 4'd1;
          if (cnt == (op_mode ? 4'd3 : 4'd11))
            state <= NORM;
        end
        NORM: begin
          Product <= result;
          done    <= 1'b1;
          state   <= DONE;
        end
        DONE: begin
          if (!start) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_fp_booth_multiplier.sv
// Directed + random bench for fp_booth_multiplier; expected results come from a
// native-multiply reference model queued per operation.
module tb_fp_booth_multiplier;

  logic        Clock = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] A = '0, B = '0;
  logic        start = 1'b0, mode = 1'b0;
  logic [31:0] Product;
  logic        done;

  int checks = 0;
  int fails  = 0;
  logic [31:0] sb_q[$];

  fp_booth_multiplier dut (
    .Clock(Clock), .reset(reset), .A(A), .B(B), .start(start), .mode(mode),
    .Product(Product), .done(done)
  );

  always #5 Clock = ~Clock;

  function automatic logic [31:0] pack(input logic s, input int e, input longint f, input logic m);
    return m ? {16'd0, s, 8'(e), 7'(f)} : {s, 8'(e), 23'(f)};
  endfunction

  // Reference: native integer multiply of significands, truncation, flush-to-zero
  function automatic logic [31:0] model(input logic [31:0] a, input logic [31:0] b, input logic m);
    int fw, ex, ey, e, sh;
    logic [31:0] x, y;
    logic s;
    longint fx, fy, p, fr, mask;
    bit nx, ny, ix, iy, zx, zy;
    fw   = m ? 7 : 23;
    x    = m ? {16'd0, a[15:0]} : a;
    y    = m ? {16'd0, b[15:0]} : b;
    s    = x[fw+8] ^ y[fw+8];
    ex   = int'(x[fw +: 8]);
    ey   = int'(y[fw +: 8]);
    mask = (longint'(1) << fw) - 1;
    fx   = longint'(x) & mask;
    fy   = longint'(y) & mask;
    nx = (ex == 255) && (fx != 0);  ny = (ey == 255) && (fy != 0);
    ix = (ex == 255) && (fx == 0);  iy = (ey == 255) && (fy == 0);
    zx = (ex == 0);                 zy = (ey == 0);
    if (nx || ny || (ix && zy) || (iy && zx)) return m ? 32'h0000_7FC0 : 32'h7FC0_0000;
    if (ix || iy) return pack(s, 255, 0, m);
    if (zx || zy) return pack(s, 0, 0, m);
    p  = ((longint'(1) << fw) | fx) * ((longint'(1) << fw) | fy);
    sh = int'((p >> (2 * fw + 1)) & 1);
    fr = (p >> (fw + sh)) & mask;
    e  = ex + ey - 127 + sh;
    if (e >= 255) return pack(s, 255, 0, m);
    if (e <= 0)   return pack(s, 0, 0, m);
    return pack(s, e, fr, m);
  endfunction

  function automatic real to_real(input logic [31:0] x);
    logic [63:0] d;
    if (x[30:23] == 8'd0) return 0.0;
    d = {x[31], 11'(int'(x[30:23]) + 896), x[22:0], 29'd0};
    return $bitstoreal(d);
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, expv);
    end
  endtask

  // One start pulse; counts edges from the sampling edge (edge 1) until done
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic m, input int lat, input bit scramble,
                       output logic [31:0] prod);
    int n;
    logic [31:0] expv;
    @(negedge Clock);
    A = a; B = b; mode = m; start = 1'b1;
    sb_q.push_back(model(a, b, m));
    @(posedge Clock);
    n = 1;
    #1 start = 1'b0;
    while (!done && n < 40) begin
      @(posedge Clock);
      n++;
      #1;
      if (scramble && n == 4) begin A = $urandom; B = $urandom; mode = ~m; end
    end
    chk({tag, "_latency"}, 32'(n), 32'(lat));
    expv = sb_q.pop_front();
    chk({tag, "_product"}, Product, expv);
    prod = Product;
    @(posedge Clock);
    #1 chk({tag, "_done_fall"}, 32'(done), 32'd0);
  endtask

  initial begin
    logic [31:0] prod, a, b;
    real rd, rf, err;
    int n;

    #12;
    chk("reset_product", Product, 32'h0);
    chk("reset_done", 32'(done), 32'd0);
    @(negedge Clock) reset = 1'b1;

    do_op("m0_1p5x2",   32'h3FC0_0000, 32'h4000_0000, 1'b0, 15, 1'b0, prod);
    chk("m0_1p5x2_const", prod, 32'h4040_0000);
    do_op("m0_neg3xhalf", 32'hC040_0000, 32'h3F00_0000, 1'b0, 15, 1'b0, prod);
    chk("m0_neg3xhalf_const", prod, 32'hBFC0_0000);
    do_op("m0_overflow", 32'h7F00_0000, 32'h7F00_0000, 1'b0, 15, 1'b0, prod);
    chk("m0_overflow_const", prod, 32'h7F80_0000);
    do_op("m0_underflow", 32'h0080_0000, 32'h0080_0000, 1'b0, 15, 1'b0, prod);
    chk("m0_underflow_const", prod, 32'h0000_0000);
    do_op("m0_infx0", 32'h7F80_0000, 32'h0000_0000, 1'b0, 15, 1'b0, prod);
    chk("m0_infx0_const", prod, 32'h7FC0_0000);
    do_op("m0_nan",  32'h7F80_0001, 32'h3F80_0000, 1'b0, 15, 1'b0, prod);
    do_op("m0_neginf", 32'hFF80_0000, 32'h4000_0000, 1'b0, 15, 1'b0, prod);
    do_op("m0_denorm", 32'h8000_0001, 32'h4000_0000, 1'b0, 15, 1'b0, prod);
    do_op("m0_allones", 32'h3FFF_FFFF, 32'h3FFF_FFFF, 1'b0, 15, 1'b0, prod);

    do_op("m1_1p5x2", 32'h0000_3FC0, 32'h0000_4000, 1'b1, 7, 1'b0, prod);
    chk("m1_1p5x2_const", prod, 32'h0000_4040);
    do_op("m1_neg1", 32'h0000_BF80, 32'h0000_3F80, 1'b1, 7, 1'b0, prod);
    chk("m1_neg1_const", prod, 32'h0000_BF80);
    do_op("m1_overflow", 32'hFFFF_7F00, 32'h1234_FF00, 1'b1, 7, 1'b0, prod);
    do_op("m1_frac", 32'h0000_3FFF, 32'h0000_C0AB, 1'b1, 7, 1'b0, prod);

    do_op("scramble", 32'h3FC0_0000, 32'h4000_0000, 1'b0, 15, 1'b1, prod);

    // Reset in the middle of an operation
    @(negedge Clock);
    A = 32'h4040_0000; B = 32'h4040_0000; mode = 1'b0; start = 1'b1;
    @(posedge Clock);
    #1 start = 1'b0;
    repeat (5) @(posedge Clock);
    @(negedge Clock) reset = 1'b0;
    #1;
    chk("midreset_done", 32'(done), 32'd0);
    chk("midreset_product", Product, 32'h0);
    @(negedge Clock) reset = 1'b1;
    do_op("post_reset", 32'h3FC0_0000, 32'h4000_0000, 1'b0, 15, 1'b0, prod);
    chk("post_reset_const", prod, 32'h4040_0000);

    // start held through completion
    @(negedge Clock);
    A = 32'h3FC0_0000; B = 32'h4000_0000; mode = 1'b0; start = 1'b1;
    sb_q.push_back(model(A, B, 1'b0));
    n = 0;
    while (!done && n < 40) begin
      @(posedge Clock);
      n++;
      #1;
    end
    chk("hold_latency", 32'(n), 32'd15);
    chk("hold_product", Product, sb_q.pop_front());
    B = 32'h4100_0000;
    repeat (20) @(posedge Clock);
    #1;
    chk("hold_done_high", 32'(done), 32'd1);
    chk("hold_product_kept", Product, 32'h4040_0000);
    @(negedge Clock) start = 1'b0;
    @(posedge Clock);
    #1 chk("hold_done_fall", 32'(done), 32'd0);
    repeat (20) @(posedge Clock);
    #1;
    chk("no_second_op", 32'(done), 32'd0);
    chk("idle_product_kept", Product, 32'h4040_0000);

    // Random normal-range binary32 pairs
    for (int i = 0; i < 100; i++) begin
      a = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      b = {1'($urandom_range(0, 1)), 8'($urandom_range(64, 190)), 23'($urandom)};
      do_op("rand", a, b, 1'b0, 15, 1'b0, prod);
      rd  = to_real(prod);
      rf  = to_real(a) * to_real(b);
      err = (rd - rf) / rf;
      if (err < 0.0) err = -err;
      checks++;
      assert (err < 1.0 / 8388608.0) else begin
        fails++;
        $error("FAIL rand_relerr: observed %h (err %g) for %h x %h", prod, err, a, b);
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
